// File: rtl/async_fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// async_fifo_pkg : pointer-width rule and gray/binary helpers for the async FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
package async_fifo_pkg;

  // Widest pointer the helpers handle; callers cast in and out of this width.
  localparam int c_PTR_MAXW = 32;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_width(input int addrsize);
    return addrsize + 1;
  endfunction

  function automatic logic [c_PTR_MAXW-1:0] bin2gray(input logic [c_PTR_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [c_PTR_MAXW-1:0] gray2bin(input logic [c_PTR_MAXW-1:0] g);
    logic [c_PTR_MAXW-1:0] b;
    b = '0;
    b[c_PTR_MAXW-1] = g[c_PTR_MAXW-1];
    for (int i = c_PTR_MAXW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rptr_empty.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rptr_empty : read-domain pointer, empty / almost-empty / level / underflow
// Rev 1.0
// ---------------------------------------------------------------------------
module rptr_empty
  import async_fifo_pkg::*;
#(
  parameter int ADDRSIZE  = 4,
  parameter int AE_THRESH = 2
) (
  input  logic                rd_clk,
  input  logic                rd_rst_n,
  input  logic                rd_en,
  input  logic [ADDRSIZE:0]   rq2_wr_ptr,
  output logic [ADDRSIZE-1:0] rd_addr,
  output logic [ADDRSIZE:0]   rd_grayptr,
  output logic                rd_empty,
  output logic                rd_almost_empty,
  output logic [ADDRSIZE:0]   rd_level,
  output logic                rd_underflow
);

  localparam int PTRW = ptr_width(ADDRSIZE);

  logic [PTRW-1:0] r_bin;
  logic [PTRW-1:0] r_gray;
  logic [PTRW-1:0] r_level;
  logic            r_empty;
  logic            r_almost_empty;
  logic            r_underflow;

  logic            w_inc;
  logic [PTRW-1:0] w_bin_nxt;
  logic [PTRW-1:0] w_gray_nxt;
  logic [PTRW-1:0] w_wbin;
  logic [PTRW-1:0] w_lvl_nxt;

  assign w_inc      = rd_en & ~r_empty;
  assign w_bin_nxt  = r_bin + {{(PTRW-1){1'b0}}, w_inc};
  assign w_gray_nxt = PTRW'(bin2gray(c_PTR_MAXW'(w_bin_nxt)));
  assign w_wbin     = PTRW'(gray2bin(c_PTR_MAXW'(rq2_wr_ptr)));
  // Modular difference; the wrap bit makes a full FIFO read as 2**ADDRSIZE.
  assign w_lvl_nxt  = w_wbin - w_bin_nxt;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_bin          <= '0;
      r_gray         <= '0;
      r_level        <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_underflow    <= 1'b0;
    end else begin
      r_bin          <= w_bin_nxt;
      r_gray         <= w_gray_nxt;
      r_level        <= w_lvl_nxt;
      r_empty        <= (w_gray_nxt == rq2_wr_ptr);
      r_almost_empty <= (w_lvl_nxt <= PTRW'(AE_THRESH));
      r_underflow    <= rd_en & r_empty;
    end
  end

  assign rd_addr         = r_bin[ADDRSIZE-1:0];
  assign rd_grayptr      = r_gray;
  assign rd_empty        = r_empty;
  assign rd_almost_empty = r_almost_empty;
  assign rd_level        = r_level;
  assign rd_underflow    = r_underflow;

endmodule
`default_nettype wire
